// File: rtl/load_result_queue.sv
// In-order MEM/WB load-result queue. Memory beats arrive in request order and are matched to
// queued loads. The queue forms the writeback value (align/extend, LWL/LWR, LL/SC) and retires one op per cycle.
module load_result_queue #(
  parameter int LANES   = 2,
  parameter int DEPTH   = 4,
  parameter bit LWLR_EN = 1'b1,
  parameter bit LLSC_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                llbit_clear,
  input  logic [LANES-1:0]    req_valid,
  output logic                req_ready,
  input  logic [LANES*4-1:0]  req_op,
  input  logic [LANES*2-1:0]  req_offset,
  input  logic [LANES*32-1:0] req_reg2,
  input  logic [LANES*5-1:0]  req_rd,
  input  logic                rsp_valid,
  input  logic [31:0]         rsp_rddata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4:0]          out_rd,
  output logic [31:0]         out_wdata,
  output logic                rsp_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [3:0] OP_LW  = 4'd0;
  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_LL  = 4'd7;
  localparam logic [3:0] OP_SC  = 4'd8;

  logic [3:0]  lane_op   [LANES];
  logic [1:0]  lane_off  [LANES];
  logic [31:0] lane_reg2 [LANES];
  logic [4:0]  lane_rd   [LANES];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_op[gi]   = req_op[gi*4 +: 4];
      assign lane_off[gi]  = req_offset[gi*2 +: 2];
      assign lane_reg2[gi] = req_reg2[gi*32 +: 32];
      assign lane_rd[gi]   = req_rd[gi*5 +: 5];
    end
  endgenerate

  logic [DEPTH-1:0] ent_valid_reg;
  logic [DEPTH-1:0] ent_has_reg;
  logic [3:0]       ent_op_reg   [DEPTH];
  logic [1:0]       ent_off_reg  [DEPTH];
  logic [31:0]      ent_reg2_reg [DEPTH];
  logic [4:0]       ent_rd_reg   [DEPTH];
  logic [31:0]      ent_data_reg [DEPTH];

  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0] count_reg, drop_cnt_reg;
  logic          link_reg, out_valid_reg, rsp_err_reg;
  logic [4:0]    out_rd_reg;
  logic [31:0]   out_wdata_reg;

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{be[b]}};
    return m;
  endfunction

  function automatic logic [31:0] form_result(input logic [3:0] op, input logic [1:0] off,
                                              input logic [31:0] reg2, input logic [31:0] data,
                                              input logic link);
    logic [31:0] a, m, mask;
    a = data >> {off, 3'b000};
    m = '0;
    mask = '0;
    case (op)
      OP_LW, OP_LL: form_result = a;
      OP_LB:        form_result = {{24{a[7]}}, a[7:0]};
      OP_LBU:       form_result = {24'b0, a[7:0]};
      OP_LH:        form_result = {{16{a[15]}}, a[15:0]};
      OP_LHU:       form_result = {16'b0, a[15:0]};
      OP_LWL: begin
        m = data << {2'd3 - off, 3'b000};
        mask = byte_mask(4'b1111 << (2'd3 - off));
        form_result = LWLR_EN ? ((reg2 & ~mask) | (m & mask)) : 32'h0;
      end
      OP_LWR: begin
        m = a;
        mask = byte_mask(4'b1111 >> off);
        form_result = LWLR_EN ? ((reg2 & ~mask) | (m & mask)) : 32'h0;
      end
      OP_SC:   form_result = LLSC_EN ? {31'b0, link} : 32'h1;
      default: form_result = reg2;
    endcase
  endfunction

  // Lane i lands after all lower-numbered valid lanes; invalid lanes take no slot.
  logic [CW-1:0] n_enq;
  logic [PW-1:0] lane_slot [LANES];
  always_comb begin
    n_enq = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_slot[i] = wr_ptr_reg + n_enq[PW-1:0];
      n_enq = n_enq + CW'(req_valid[i]);
    end
  end

  // Oldest data-waiting entry receives the next beat; also count all such entries.
  logic          tgt_found;
  logic [PW-1:0] tgt_idx, scan_idx;
  logic [CW-1:0] unfilled;
  always_comb begin
    tgt_found = 1'b0;
    tgt_idx   = '0;
    scan_idx  = '0;
    unfilled  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = rd_ptr_reg + PW'(k);
      if (ent_valid_reg[scan_idx] && !ent_op_reg[scan_idx][3] && !ent_has_reg[scan_idx]) begin
        if (!tgt_found) begin
          tgt_found = 1'b1;
          tgt_idx   = scan_idx;
        end
        unfilled = unfilled + CW'(1);
      end
    end
  end

  logic        drop_dec, rsp_match, rsp_orphan;
  logic        head_need, head_ready, load, enq_en;
  logic [3:0]  head_op;
  logic [31:0] head_result;
  logic [CW:0] drop_sum;

  assign drop_dec   = rsp_valid && (drop_cnt_reg != '0);
  assign rsp_match  = rsp_valid && (drop_cnt_reg == '0) && tgt_found;
  assign rsp_orphan = rsp_valid && (drop_cnt_reg == '0) && !tgt_found;

  assign head_op     = ent_op_reg[rd_ptr_reg];
  assign head_need   = !head_op[3];
  assign head_ready  = ent_valid_reg[rd_ptr_reg] && (!head_need || ent_has_reg[rd_ptr_reg]);
  assign load        = !flush && head_ready && (!out_valid_reg || out_ready);
  assign head_result = form_result(head_op, ent_off_reg[rd_ptr_reg], ent_reg2_reg[rd_ptr_reg],
                                   ent_data_reg[rd_ptr_reg], link_reg);

  assign req_ready = (count_reg <= CW'(DEPTH - LANES));
  assign enq_en    = req_ready && !flush;

  // Every flushed load still owes one beat; a beat matched this cycle has already been paid.
  assign drop_sum = {1'b0, drop_cnt_reg} - (CW+1)'(drop_dec) + {1'b0, unfilled}
                  - (CW+1)'(rsp_match);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      drop_cnt_reg  <= '0;
      link_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_rd_reg    <= '0;
      out_wdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      ent_valid_reg <= '0;
      ent_has_reg   <= '0;
    end else begin
      if (rsp_orphan) rsp_err_reg <= 1'b1;

      if (llbit_clear) link_reg <= 1'b0;
      else if (load && LLSC_EN && head_op == OP_LL) link_reg <= 1'b1;
      else if (load && LLSC_EN && head_op == OP_SC) link_reg <= 1'b0;

      if (flush) begin
        rd_ptr_reg    <= '0;
        wr_ptr_reg    <= '0;
        count_reg     <= '0;
        ent_valid_reg <= '0;
        ent_has_reg   <= '0;
        out_valid_reg <= 1'b0;
        drop_cnt_reg  <= (drop_sum > (CW+1)'(DEPTH)) ? CW'(DEPTH) : drop_sum[CW-1:0];
      end else begin
        if (drop_dec) drop_cnt_reg <= drop_cnt_reg - CW'(1);
        if (rsp_match) begin
          ent_has_reg[tgt_idx]  <= 1'b1;
          ent_data_reg[tgt_idx] <= rsp_rddata;
        end
        if (load) begin
          out_valid_reg             <= 1'b1;
          out_rd_reg                <= ent_rd_reg[rd_ptr_reg];
          out_wdata_reg             <= head_result;
          ent_valid_reg[rd_ptr_reg] <= 1'b0;
          rd_ptr_reg                <= rd_ptr_reg + PW'(1);
        end else if (out_ready) begin
          out_valid_reg <= 1'b0;
        end
        if (enq_en) begin
          for (int i = 0; i < LANES; i++) begin
            if (req_valid[i]) begin
              ent_valid_reg[lane_slot[i]] <= 1'b1;
              ent_has_reg[lane_slot[i]]   <= 1'b0;
              ent_op_reg[lane_slot[i]]    <= lane_op[i];
              ent_off_reg[lane_slot[i]]   <= lane_off[i];
              ent_reg2_reg[lane_slot[i]]  <= lane_reg2[i];
              ent_rd_reg[lane_slot[i]]    <= lane_rd[i];
            end
          end
          wr_ptr_reg <= wr_ptr_reg + n_enq[PW-1:0];
        end
        count_reg <= count_reg + (enq_en ? n_enq : CW'(0)) - CW'(load);
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_rd    = out_rd_reg;
  assign out_wdata = out_wdata_reg;
  assign rsp_err   = rsp_err_reg;
endmodule

// File: tb/tb_load_result_queue.sv
// Bench for load_result_queue: directed spec cases plus randomized traffic, all checked each
// cycle against a queue-level reference model.
module tb_load_result_queue;
  localparam int LANES = 2;
  localparam int DEPTH = 4;

  logic                clk = 1'b0;
  logic                rst, flush, llbit_clear;
  logic [LANES-1:0]    req_valid;
  logic                req_ready;
  logic [LANES*4-1:0]  req_op;
  logic [LANES*2-1:0]  req_offset;
  logic [LANES*32-1:0] req_reg2;
  logic [LANES*5-1:0]  req_rd;
  logic                rsp_valid;
  logic [31:0]         rsp_rddata;
  logic                out_valid, out_ready;
  logic [4:0]          out_rd;
  logic [31:0]         out_wdata;
  logic                rsp_err;

  load_result_queue #(.LANES(LANES), .DEPTH(DEPTH), .LWLR_EN(1'b1), .LLSC_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .llbit_clear(llbit_clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_offset(req_offset),
    .req_reg2(req_reg2), .req_rd(req_rd), .rsp_valid(rsp_valid), .rsp_rddata(rsp_rddata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_wdata(out_wdata),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  off;
    logic [31:0] reg2;
    logic [4:0]  rd;
    bit          has;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  int          m_drop;
  bit          m_link, m_ov, m_err;
  logic [4:0]  m_rd;
  logic [31:0] m_wdata;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic bit needs_data(input logic [3:0] op);
    return op <= 4'd7;
  endfunction

  function automatic int count_unfilled();
    int n = 0;
    foreach (mq[k]) if (needs_data(mq[k].op) && !mq[k].has) n++;
    return n;
  endfunction

  // Writeback value from the architectural load definitions.
  function automatic logic [31:0] ref_result(input ent_t e, input bit link);
    logic [31:0] a, m, r;
    byte         b8;
    shortint     h16;
    int          v, s;
    a = e.data >> (8 * int'(e.off));
    s = 3 - int'(e.off);
    r = e.reg2;
    case (e.op)
      4'd0, 4'd7: r = a;
      4'd1: begin b8 = a[7:0]; v = b8; r = v; end
      4'd2: r = a & 32'h0000_00FF;
      4'd3: begin h16 = a[15:0]; v = h16; r = v; end
      4'd4: r = a & 32'h0000_FFFF;
      4'd5: begin
        m = e.data << (8 * s);
        for (int b = 0; b < 4; b++) if (b >= s) r[b*8 +: 8] = m[b*8 +: 8];
      end
      4'd6: begin
        for (int b = 0; b < 4; b++) if (b <= s) r[b*8 +: 8] = a[b*8 +: 8];
      end
      4'd8: r = {31'b0, link};
      default: r = e.reg2;
    endcase
    return r;
  endfunction

  task automatic model_update();
    bit          ld, pre_ready, found;
    logic [31:0] res;
    logic [4:0]  rdv;
    logic [3:0]  hop;
    ent_t        e;
    pre_ready = (DEPTH - mq.size()) >= LANES;
    if (rst) begin
      mq.delete();
      m_drop = 0; m_link = 0; m_ov = 0; m_rd = '0; m_wdata = '0; m_err = 0;
      return;
    end
    ld = !flush && mq.size() > 0 && (!needs_data(mq[0].op) || mq[0].has) && (!m_ov || out_ready);
    res = '0; rdv = '0; hop = '0;
    if (ld) begin
      res = ref_result(mq[0], m_link);
      rdv = mq[0].rd;
      hop = mq[0].op;
    end
    if (rsp_valid) begin
      if (m_drop > 0) m_drop--;
      else begin
        found = 0;
        foreach (mq[k]) begin
          if (!found && needs_data(mq[k].op) && !mq[k].has) begin
            e = mq[k]; e.has = 1; e.data = rsp_rddata; mq[k] = e;
            found = 1;
          end
        end
        if (!found) m_err = 1;
      end
    end
    if (llbit_clear) m_link = 0;
    else if (ld && hop == 4'd7) m_link = 1;
    else if (ld && hop == 4'd8) m_link = 0;
    if (flush) begin
      m_drop = m_drop + count_unfilled();
      if (m_drop > DEPTH) m_drop = DEPTH;
      mq.delete();
      m_ov = 0;
    end else begin
      if (ld) begin
        void'(mq.pop_front());
        m_ov = 1; m_rd = rdv; m_wdata = res;
      end else if (out_ready) m_ov = 0;
      if (pre_ready) begin
        for (int l = 0; l < LANES; l++) begin
          if (req_valid[l]) begin
            e.op = req_op[l*4 +: 4]; e.off = req_offset[l*2 +: 2];
            e.reg2 = req_reg2[l*32 +: 32]; e.rd = req_rd[l*5 +: 5];
            e.has = 0; e.data = '0;
            mq.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic step();
    if (!rst && m_ov && out_ready) $display("wb rd=%0d data=%08h", m_rd, m_wdata);
    model_update();
    @(posedge clk);
    #1;
    rst = 0; flush = 0; llbit_clear = 0; req_valid = '0; rsp_valid = 0;
    check("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      check("out_rd", 32'(out_rd), 32'(m_rd));
      check("out_wdata", out_wdata, m_wdata);
    end
    check("req_ready", 32'(req_ready), 32'((DEPTH - mq.size()) >= LANES));
    check("rsp_err", 32'(rsp_err), 32'(m_err));
    check("drop_cnt", 32'(dut.drop_cnt_reg), 32'(m_drop));
  endtask

  task automatic drive_lane(input int l, input logic [3:0] op, input logic [1:0] off,
                            input logic [31:0] reg2, input logic [4:0] rd);
    req_valid[l] = 1'b1;
    req_op[l*4 +: 4] = op;
    req_offset[l*2 +: 2] = off;
    req_reg2[l*32 +: 32] = reg2;
    req_rd[l*5 +: 5] = rd;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, 32'(out_valid), 32'd1);
  endtask

  task automatic one_load(input string tag, input logic [3:0] op, input logic [1:0] off,
                          input logic [31:0] reg2, input logic [31:0] data,
                          input logic [31:0] exp);
    drive_lane(0, op, off, reg2, 5'd9);
    step();
    rsp_valid = 1; rsp_rddata = data;
    step();
    wait_out(tag);
    check(tag, out_wdata, exp);
    step();
  endtask

  task automatic one_pass(input string tag, input logic [3:0] op, input logic [31:0] reg2,
                          input logic [31:0] exp);
    drive_lane(0, op, 2'd0, reg2, 5'd10);
    step();
    wait_out(tag);
    check(tag, out_wdata, exp);
    step();
  endtask

  initial begin
    rst = 1; flush = 0; llbit_clear = 0; req_valid = '0; req_op = '0; req_offset = '0;
    req_reg2 = '0; req_rd = '0; rsp_valid = 0; rsp_rddata = '0; out_ready = 1;
    step();
    check("reset_out_rd", 32'(out_rd), 32'd0);
    check("reset_out_wdata", out_wdata, 32'd0);

    one_load("lb_off3", 4'd1, 2'd3, 32'h0, 32'h80FF_1234, 32'hFFFF_FF80);
    one_load("lbu_off3", 4'd2, 2'd3, 32'h0, 32'h80FF_1234, 32'h0000_0080);
    one_load("lhu_off2", 4'd4, 2'd2, 32'h0, 32'h80FF_1234, 32'h0000_80FF);
    one_load("lwl_off1", 4'd5, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h3344_CCDD);
    one_load("lwr_off1", 4'd6, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'hAA11_2233);

    // Dual-lane issue, beats on consecutive cycles, retire in lane order.
    drive_lane(0, 4'd0, 2'd0, 32'h0, 5'd3);
    drive_lane(1, 4'd0, 2'd0, 32'h0, 5'd4);
    step();
    rsp_valid = 1; rsp_rddata = 32'h1; step();
    rsp_valid = 1; rsp_rddata = 32'h2; step();
    check("b2b_first_rd", 32'(out_rd), 32'd3);
    check("b2b_first_data", out_wdata, 32'h1);
    step();
    check("b2b_second_rd", 32'(out_rd), 32'd4);
    check("b2b_second_data", out_wdata, 32'h2);
    step();

    // Three outstanding loads fill past the issue threshold, then flush.
    drive_lane(0, 4'd0, 2'd0, 32'h0, 5'd1);
    drive_lane(1, 4'd0, 2'd0, 32'h0, 5'd2);
    step();
    drive_lane(0, 4'd0, 2'd0, 32'h0, 5'd3);
    step();
    check("full_ready", 32'(req_ready), 32'd0);
    flush = 1; step();
    check("flush_ready", 32'(req_ready), 32'd1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      rsp_valid = 1; rsp_rddata = 32'hDEAD_0000 + 32'(i); step();
      check("late_beat_dropped", 32'(rsp_err), 32'd0);
    end
    rsp_valid = 1; rsp_rddata = 32'hBEEF; step();
    check("orphan_beat", 32'(rsp_err), 32'd1);
    rst = 1; step();
    check("err_cleared", 32'(rsp_err), 32'd0);

    // LL/SC link behaviour.
    one_load("ll_value", 4'd7, 2'd0, 32'h0, 32'hCAFE_0001, 32'hCAFE_0001);
    one_pass("sc_linked", 4'd8, 32'h5555_5555, 32'h1);
    one_load("ll_value2", 4'd7, 2'd0, 32'h0, 32'hCAFE_0002, 32'hCAFE_0002);
    llbit_clear = 1; step();
    one_pass("sc_cleared", 4'd8, 32'h5555_5555, 32'h0);
    one_load("ll_value3", 4'd7, 2'd0, 32'h0, 32'hCAFE_0003, 32'hCAFE_0003);
    drive_lane(0, 4'd7, 2'd0, 32'h0, 5'd11);
    step();
    rsp_valid = 1; rsp_rddata = 32'hCAFE_0004; step();
    llbit_clear = 1; step();
    check("ll_race_data", out_wdata, 32'hCAFE_0004);
    step();
    one_pass("sc_after_race", 4'd8, 32'h5555_5555, 32'h0);

    // Stalled output holds while two PASS ops wait.
    out_ready = 0;
    drive_lane(0, 4'd15, 2'd0, 32'h1234_5678, 5'd7);
    drive_lane(1, 4'd12, 2'd0, 32'h9ABC_DEF0, 5'd8);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_rd", 32'(out_rd), 32'd7);
      check("stall_data", out_wdata, 32'h1234_5678);
    end
    out_ready = 1; step();
    check("release_rd", 32'(out_rd), 32'd8);
    check("release_data", out_wdata, 32'h9ABC_DEF0);
    step();
    check("release_drained", 32'(out_valid), 32'd0);

    // Reset in the middle of a stalled stream with the error flag set.
    out_ready = 0;
    drive_lane(0, 4'd15, 2'd0, 32'h0BAD_F00D, 5'd12);
    step();
    rsp_valid = 1; rsp_rddata = 32'h77; step();
    rst = 1; step();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_rsp_err", 32'(rsp_err), 32'd0);
    out_ready = 1;

    // Randomized traffic; beats only when one is owed, never alongside a flush.
    for (int c = 0; c < 600; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      for (int l = 0; l < LANES; l++)
        if ($urandom_range(0, 1) == 1)
          drive_lane(l, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), $urandom,
                     5'($urandom_range(0, 31)));
      if ((m_drop + count_unfilled()) > 0 && $urandom_range(0, 1) == 1) begin
        rsp_valid = 1; rsp_rddata = $urandom;
      end else if ($urandom_range(0, 39) == 0) begin
        flush = 1;
      end
      if ($urandom_range(0, 15) == 0) llbit_clear = 1;
      step();
    end
    out_ready = 1;
    for (int i = 0; i < 10; i++) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
